// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU controller: opcodes, FSM states
// and the default operand width.
package alu_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring
// shift-subtract step per enable. Accumulator holds {hi, lo}.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_en,
    input  logic                 i_div,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic [SW-1:0]        o_step
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [SW-1:0]      r_step;
    logic               r_div;

    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_next;

    always_comb begin
        w_hi     = r_acc[2*WIDTH-1:WIDTH];
        w_lo     = r_acc[WIDTH-1:0];
        w_add    = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opnd} : '0);
        w_rem_sh = {w_hi, w_lo[WIDTH-1]};
        // Remainder stays below the divisor, so bit WIDTH of the trial is a clean borrow.
        w_trial  = w_rem_sh - {1'b0, r_opnd};
        w_next   = '0;
        if (!r_div)
            w_next = {w_add, w_lo[WIDTH-1:1]};
        else if (w_trial[WIDTH])
            w_next = {w_rem_sh[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0};
        else
            w_next = {w_trial[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_opnd <= '0;
            r_step <= '0;
            r_div  <= 1'b0;
        end else if (i_load) begin
            r_acc  <= {{WIDTH{1'b0}}, i_a};
            r_opnd <= i_b;
            r_step <= '0;
            r_div  <= i_div;
        end else if (i_en) begin
            r_acc  <= w_next;
            r_step <= r_step + SW'(1);
        end
    end

    assign o_acc  = r_acc;
    assign o_step = r_step;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU controller: accepts one command at a time, runs add/sub in a
// single cycle and mul/div through muldiv_iter, then reports result and flags.
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on accept
// S_CALC | iterating (r_fin low), then registering result/flags
// S_DONE | one-cycle done pulse; back to IDLE next edge
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero,
    output logic                 sign,
    output logic                 carry,
    output logic                 parity,
    output logic                 overflow,
    output logic                 dbz
);

    localparam int SW = $clog2(WIDTH);

    state_t             r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_md;
    logic               r_dbz;
    logic               r_fin;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_result;
    logic               r_zero, r_sign, r_carry, r_parity, r_overflow, r_dbz_flag;

    logic               w_accept;
    logic               w_iter_en;
    logic [2*WIDTH-1:0] w_acc;
    logic [SW-1:0]      w_step;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_result;
    logic               w_wide;
    logic               w_zero, w_sign, w_carry, w_parity, w_overflow, w_dbz;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_iter_en = (r_state == S_CALC) && !r_fin && r_md;
    assign w_last    = (w_step == SW'(WIDTH - 1));

    muldiv_iter #(.WIDTH(WIDTH), .SW(SW)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_en   (w_iter_en),
        .i_div  (op == OP_DIV),
        .i_a    (a),
        .i_b    (b),
        .o_acc  (w_acc),
        .o_step (w_step)
    );

    always_comb begin
        w_sum      = {1'b0, r_a} + {1'b0, r_b};
        w_diff     = {1'b0, r_a} - {1'b0, r_b};
        w_result   = '0;
        w_wide     = 1'b0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        w_dbz      = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_result   = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
                w_carry    = w_sum[WIDTH];
                w_overflow = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_result   = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
                w_carry    = w_diff[WIDTH];
                w_overflow = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_MUL: begin
                w_result   = w_acc;
                w_wide     = 1'b1;
                w_overflow = |w_acc[2*WIDTH-1:WIDTH];
            end
            default: begin
                w_result = w_acc;
            end
        endcase
        if (w_wide) begin
            w_zero   = (w_result == '0);
            w_sign   = w_result[2*WIDTH-1];
            w_parity = ^w_result;
        end else begin
            w_zero   = (w_result[WIDTH-1:0] == '0);
            w_sign   = w_result[WIDTH-1];
            w_parity = ^w_result[WIDTH-1:0];
        end
        // Divide by zero reports only dbz, even though the result reads as zero.
        if (r_dbz) begin
            w_result   = '0;
            w_zero     = 1'b0;
            w_sign     = 1'b0;
            w_carry    = 1'b0;
            w_parity   = 1'b0;
            w_overflow = 1'b0;
            w_dbz      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_ADD;
            r_a        <= '0;
            r_b        <= '0;
            r_md       <= 1'b0;
            r_dbz      <= 1'b0;
            r_fin      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_sign     <= 1'b0;
            r_carry    <= 1'b0;
            r_parity   <= 1'b0;
            r_overflow <= 1'b0;
            r_dbz_flag <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_dbz   <= (op == OP_DIV) && (b == '0);
                        r_md    <= (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
                        r_fin   <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (!r_fin) begin
                        r_fin <= !r_md || w_last;
                    end else begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_result   <= w_result;
                        r_zero     <= w_zero;
                        r_sign     <= w_sign;
                        r_carry    <= w_carry;
                        r_parity   <= w_parity;
                        r_overflow <= w_overflow;
                        r_dbz_flag <= w_dbz;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign zero     = r_zero;
    assign sign     = r_sign;
    assign carry    = r_carry;
    assign parity   = r_parity;
    assign overflow = r_overflow;
    assign dbz      = r_dbz_flag;

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width; result width is 2*WIDTH.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  command request; sampled only in IDLE.
REQ-006 op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 a, b  input  WIDTH each  operands; captured on an accepted start.
REQ-008 busy  output  1  high in CALC and DONE states.
REQ-009 done  output  1  one-cycle pulse; result and flags valid.
REQ-010 result  output  2*WIDTH  add/sub: zero-extended sum/difference; mul: full product; div: remainder[15:8], quotient[7:0].
REQ-011 zero, sign, carry, parity, overflow, dbz  output  1 each  registered status flags.

Function
REQ-012 FSM states: IDLE, CALC, DONE; IDLE->CALC on start, CALC->DONE after the op's iterations, DONE->IDLE unconditionally.
REQ-013 An accepted start latches op, a, b; later input changes have no effect until the next accepted start.
REQ-014 start while busy is ignored, with no queuing.
REQ-015 add/sub: one CALC cycle; start accepted at edge k -> done high after edge k+2.
REQ-016 mul: 8 shift-add iterations, one per CALC cycle; done high after edge k+9.
REQ-017 div: 8 restoring shift-subtract iterations; done high after edge k+9.
REQ-018 div with b==0: no iterations; result 0, dbz=1, other flags 0; done high after edge k+2.
REQ-019 zero: 1 when the op's valid result field is all zeros (8-bit for add/sub/div quotient, 16-bit for mul).
REQ-020 sign: MSB of that same field.
REQ-021 parity: XOR-reduction of that same field (1 = odd number of ones).
REQ-022 carry: add = carry-out of bit 7; sub = borrow (a<b unsigned); mul/div = 0.
REQ-023 overflow: add/sub = two's-complement signed overflow; mul = result[15:8]!=0; div = 0.
REQ-024 result and flags update only at the CALC->DONE transition, and hold until the next completion.
REQ-025 done is low in every state except DONE.
REQ-026 start is accepted in the cycle after DONE, giving back-to-back commands one idle cycle apart.

Reset
REQ-027 rst forces IDLE, busy=0, done=0, result=0, and all flags=0, asynchronously and at any point, including mid-iteration.
REQ-028 An aborted operation produces no done pulse and leaves no partial result visible.
REQ-029 The first start after rst deasserts is accepted normally.

Structure
REQ-030 Shared package alu_pkg holds: opcode constants (ADD, SUB, MUL, DIV), the FSM state enum, and the WIDTH default.
REQ-031 One sub-module, muldiv_iter, holds the iteration datapath:
- ports: accumulator, multiplicand/divisor, 3-bit step counter;
- one step per enable;
- alu_seq_ctrl owns the FSM and the flags.

Verification
REQ-032 add a=0xFF, b=0x01 -> done at k+2; result=0x0000; zero=1, carry=1, overflow=0, sign=0, parity=0.
REQ-033 sub a=0x80, b=0x01 -> result=0x007F; overflow=1, carry=0, sign=0, parity=1; sub a=0x01, b=0x02 -> result=0x00FF, carry=1, sign=1.
REQ-034 mul a=0xFF, b=0xFF -> done at k+9; result=0xFE01, overflow=1; mul 0x0F*0x11 -> 0x00FF, overflow=0, parity=0.
REQ-035 div a=0xC8, b=0x07 -> done at k+9; result=0x041C; div a=0x55, b=0x00 -> done at k+2, result=0, dbz=1.
REQ-036 start pulsed during a mul at k+4 -> ignored; exactly one done, and the result matches the first command.
REQ-037 rst asserted at k+5 of a div -> outputs 0 immediately and no done; a new add 0x03+0x04 completes with 0x0007.
